// File: rtl/axil_slave_regs.sv
// AXI4-Lite register responder: NUM_REGS byte-strobed 32-bit registers behind
// independent single-outstanding write and read channels.
module axil_slave_regs #(
  parameter int unsigned NUM_REGS   = 4,
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                             ACLK,
  input  logic                             ARESET,
  input  logic [ADDR_WIDTH-1:0]            S_AWADDR,
  input  logic [2:0]                       S_AWPROT,
  input  logic                             S_AWVALID,
  output logic                             S_AWREADY,
  input  logic [DATA_WIDTH-1:0]            S_WDATA,
  input  logic [DATA_WIDTH/8-1:0]          S_WSTRB,
  input  logic                             S_WVALID,
  output logic                             S_WREADY,
  output logic [1:0]                       S_BRESP,
  output logic                             S_BVALID,
  input  logic                             S_BREADY,
  input  logic [ADDR_WIDTH-1:0]            S_ARADDR,
  input  logic [2:0]                       S_ARPROT,
  input  logic                             S_ARVALID,
  output logic                             S_ARREADY,
  output logic [DATA_WIDTH-1:0]            S_RDATA,
  output logic [1:0]                       S_RRESP,
  output logic                             S_RVALID,
  input  logic                             S_RREADY,
  output logic [NUM_REGS*DATA_WIDTH-1:0]   reg_out,
  output logic [NUM_REGS-1:0]              reg_wr_pulse
);

  localparam int unsigned IDX_W       = ADDR_WIDTH - 2;
  localparam int unsigned STRB_W      = DATA_WIDTH / 8;
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;

  logic                  awready_q, awready_d;
  logic                  wready_q,  wready_d;
  logic                  aw_lat_q,  aw_lat_d;
  logic                  w_lat_q,   w_lat_d;
  logic [IDX_W-1:0]      wr_idx_q,  wr_idx_d;
  logic [DATA_WIDTH-1:0] wdata_q,   wdata_d;
  logic [STRB_W-1:0]     wstrb_q,   wstrb_d;
  logic                  bvalid_q,  bvalid_d;
  logic [1:0]            bresp_q,   bresp_d;
  logic [NUM_REGS-1:0]   pulse_q,   pulse_d;
  logic                  arready_q, arready_d;
  logic                  rvalid_q,  rvalid_d;
  logic [DATA_WIDTH-1:0] rdata_q,   rdata_d;
  logic [1:0]            rresp_q,   rresp_d;
  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];

  logic                  wr_mapped_c;
  logic [IDX_W-1:0]      rd_idx_c;
  logic                  rd_mapped_c;
  logic                  unused_c;

  // Protection bits and the byte offset within a word carry no meaning here.
  assign unused_c = ^{S_AWPROT, S_ARPROT, S_AWADDR[1:0], S_ARADDR[1:0]};

  assign wr_mapped_c = (32'(wr_idx_q) < NUM_REGS);
  assign rd_idx_c    = S_ARADDR[ADDR_WIDTH-1:2];
  assign rd_mapped_c = (32'(rd_idx_c) < NUM_REGS);

  // Write path: latch AW and W independently, commit once both are held.
  always_comb begin
    aw_lat_d = aw_lat_q;
    w_lat_d  = w_lat_q;
    wr_idx_d = wr_idx_q;
    wdata_d  = wdata_q;
    wstrb_d  = wstrb_q;
    bvalid_d = bvalid_q;
    bresp_d  = bresp_q;
    pulse_d  = '0;
    regs_d   = regs_q;

    if (S_AWVALID && awready_q) begin
      aw_lat_d = 1'b1;
      wr_idx_d = S_AWADDR[ADDR_WIDTH-1:2];
    end
    if (S_WVALID && wready_q) begin
      w_lat_d = 1'b1;
      wdata_d = S_WDATA;
      wstrb_d = S_WSTRB;
    end

    if (aw_lat_q && w_lat_q) begin
      aw_lat_d = 1'b0;
      w_lat_d  = 1'b0;
      bvalid_d = 1'b1;
      bresp_d  = wr_mapped_c ? RESP_OKAY : RESP_SLVERR;
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        if (wr_idx_q == IDX_W'(i)) begin
          pulse_d[i] = 1'b1;
          for (int unsigned b = 0; b < STRB_W; b++) begin
            if (wstrb_q[b]) regs_d[i][8*b +: 8] = wdata_q[8*b +: 8];
          end
        end
      end
    end else if (bvalid_q && S_BREADY) begin
      bvalid_d = 1'b0;
    end

    awready_d = !aw_lat_d && !bvalid_d;
    wready_d  = !w_lat_d && !bvalid_d;
  end

  // Read path: snapshot the pre-commit register value on the AR handshake.
  always_comb begin
    rvalid_d = rvalid_q;
    rdata_d  = rdata_q;
    rresp_d  = rresp_q;

    if (S_ARVALID && arready_q) begin
      rvalid_d = 1'b1;
      rdata_d  = '0;
      rresp_d  = rd_mapped_c ? RESP_OKAY : RESP_SLVERR;
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        if (rd_idx_c == IDX_W'(i)) rdata_d = regs_q[i];
      end
    end else if (rvalid_q && S_RREADY) begin
      rvalid_d = 1'b0;
    end

    arready_d = !rvalid_d;
  end

  always_comb begin
    reg_out = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      reg_out[DATA_WIDTH*i +: DATA_WIDTH] = regs_q[i];
    end
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      awready_q <= 1'b1;
      wready_q  <= 1'b1;
      aw_lat_q  <= 1'b0;
      w_lat_q   <= 1'b0;
      wr_idx_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      pulse_q   <= '0;
      arready_q <= 1'b1;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
      regs_q    <= '{default: '0};
    end else begin
      awready_q <= awready_d;
      wready_q  <= wready_d;
      aw_lat_q  <= aw_lat_d;
      w_lat_q   <= w_lat_d;
      wr_idx_q  <= wr_idx_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      pulse_q   <= pulse_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
      regs_q    <= regs_d;
    end
  end

  assign S_AWREADY    = awready_q;
  assign S_WREADY     = wready_q;
  assign S_BVALID     = bvalid_q;
  assign S_BRESP      = bresp_q;
  assign S_ARREADY    = arready_q;
  assign S_RVALID     = rvalid_q;
  assign S_RDATA      = rdata_q;
  assign S_RRESP      = rresp_q;
  assign reg_wr_pulse = pulse_q;

endmodule

// File: doc/axil_slave_regs.md
Name: axil_slave_regs

Overview:
AXI4-Lite responder (slave) that terminates the master VIP's write and read traffic in the block-design wrapper. It holds NUM_REGS 32-bit software registers behind byte-strobed writes and exposes them to fabric logic. Default address map: 0x00, 0x04, 0x08, 0x0C hold regs 0-3; 0x10-0x1C are unmapped and return SLVERR. One outstanding write and one outstanding read; the write and read channels run independently.

Parameters:
NUM_REGS, 4, number of 32-bit registers (1..2^(ADDR_WIDTH-2))
ADDR_WIDTH, 5, AXI address width; register index = ADDR[ADDR_WIDTH-1:2]
DATA_WIDTH, 32, fixed at 32

Ports:
ACLK  in  1  clock; all logic on the rising edge
ARESET  in  1  synchronous, active-high reset
S_AWADDR  in  ADDR_WIDTH  write address
S_AWPROT  in  3  ignored
S_AWVALID  in  1  write address valid
S_AWREADY  out  1  write address ready
S_WDATA  in  32  write data
S_WSTRB  in  4  byte strobes
S_WVALID  in  1  write data valid
S_WREADY  out  1  write data ready
S_BRESP  out  2  00 OKAY, 10 SLVERR
S_BVALID  out  1  write response valid
S_BREADY  in  1  write response ready
S_ARADDR  in  ADDR_WIDTH  read address
S_ARPROT  in  3  ignored
S_ARVALID  in  1  read address valid
S_ARREADY  out  1  read address ready
S_RDATA  out  32  read data
S_RRESP  out  2  00 OKAY, 10 SLVERR
S_RVALID  out  1  read data valid
S_RREADY  in  1  read data ready
reg_out  out  NUM_REGS*32  register contents; reg i = bits [32i+31:32i]
reg_wr_pulse  out  NUM_REGS  1-cycle pulse on the cycle after reg i is written

Behaviour:
- Reset (ARESET=1 at a rising edge): all registers 0; AWREADY, WREADY, ARREADY = 1; BVALID, RVALID = 0; BRESP, RRESP, RDATA = 0; reg_wr_pulse = 0; latched AW/W flags cleared. An in-flight transaction is discarded without a response.
- Write path: the AW and W handshakes are independent, and either may come first.
  - AWREADY = 1 while no address is latched and BVALID = 0.
  - WREADY = 1 while no data is latched and BVALID = 0.
  - An AW handshake latches the address and drops AWREADY. A W handshake latches data and strobes and drops WREADY.
  - Both handshakes may occur in the same cycle.
- Write commit: on the first edge where both address and data are latched (registered flags), the write is committed.
  - Mapped index: each byte b with WSTRB[b] = 1 updates reg[idx][8b+7:8b]. BRESP = OKAY.
  - Unmapped index (idx >= NUM_REGS): no register changes. BRESP = SLVERR.
  - BVALID rises on the same edge. reg_wr_pulse[idx] is high for exactly that one following cycle, and only for mapped writes; WSTRB = 0 still pulses.
  - Latency: best case, AW+W accepted at edge N, commit and BVALID at edge N+1.
- B channel: BVALID holds with stable BRESP until BREADY = 1. On the B handshake, BVALID drops and both AWREADY and WREADY return to 1 on the same edge. Next acceptance is at the following edge (no back-to-back overlap).
- Read path:
  - ARREADY = 1 while RVALID = 0.
  - On an AR handshake, RDATA is captured from the register contents at that edge (pre-write value if a write commits on the same edge). RRESP = OKAY if mapped; otherwise RDATA = 0 and RRESP = SLVERR. RVALID rises and ARREADY drops on the same edge (1-cycle latency).
  - RVALID, RDATA and RRESP hold until RREADY = 1. On the R handshake, RVALID drops and ARREADY rises.
- Simultaneous read and write to the same register: the read returns the old value, and a subsequent read returns the new value.
- Outputs never depend combinationally on inputs; all READY/VALID/data are registered.
- AWPROT and ARPROT are ignored. Address bits [1:0] are ignored (unaligned addresses are treated as aligned).

Test Plan:
1. Sequential writes of 0x1, 0x2, 0x3, 0x4 to 0x00, 0x04, 0x08, 0x0C, with WSTRB = 0xF and BREADY tied high -> each BRESP = OKAY, reg_out = {4,3,2,1}. Then read 0x00-0x0C -> RDATA 1, 2, 3, 4, RRESP = OKAY.
2. Write 0xAABBCCDD to 0x04 with WSTRB = 0xF, then 0x11223344 with WSTRB = 0b0101 -> read 0x04 returns 0xAA22CC44. reg_wr_pulse[1] pulses once per write.
3. W presented 3 cycles before AW; then AW-only with W delayed 2 cycles -> single commit each time, correct data, BVALID one cycle after the later handshake.
4. Hold BREADY = 0 for 5 cycles after a write -> BVALID and BRESP stable, AWREADY = WREADY = 0 throughout. Hold RREADY = 0 for 5 cycles -> RDATA stable, ARREADY = 0.
5. Write 0xDEADBEEF to 0x14, then read 0x18 -> BRESP = SLVERR with no reg change and no pulse; RRESP = SLVERR with RDATA = 0.
6. Assert ARESET while BVALID = 1 and reg0 = 0x5 -> next cycle BVALID = 0, all READY = 1, reg_out = 0, read 0x00 returns 0.
